// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state type and default operand width for serial_adder
package serial_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit combinational adder; a, b, cin -> s, cout
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder; start/a/b/cin in, busy/done pulse/registered sum/cout out
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, ps;
  logic carry, s, co;
  logic [CW-1:0] cnt;
  full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .s(s), .cout(co));
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      ps <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        a_sr <= a;
        b_sr <= b;
        carry <= cin;
        cnt <= '0;
      end
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      ps <= {s, ps[WIDTH-1:1]};
      carry <= co;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        state <= DONE;
        sum <= {s, ps[WIDTH-1:1]};
        cout <= co;
      end
    end else
      state <= IDLE;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven and directed self-checking bench for serial_adder
module tb_serial_adder;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic cin = 1'b0;
  logic busy, done, cout;
  logic [7:0] sum;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vt[11];
  vec_t hs[3];
  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    int lat, ndone, gap;
    logic [7:0] got_s;
    logic got_c;
    vt[0]  = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0};
    vt[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vt[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[5]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vt[6]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vt[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[8]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vt[9]  = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vt[10] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
    hs[0]  = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    hs[1]  = '{8'h40, 8'h41, 1'b1, 8'h82, 1'b0};
    hs[2]  = '{8'hF0, 8'hF0, 1'b0, 8'hE0, 1'b1};
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    for (int i = 0; i < 11; i++) begin
      launch(vt[i].a, vt[i].b, vt[i].cin);
      chk($sformatf("v%0d busy in run", i), busy, 1);
      a = ~vt[i].a;
      b = ~vt[i].b;
      cin = ~vt[i].cin;
      wait_done(lat);
      chk($sformatf("v%0d latency", i), lat, 9);
      chk($sformatf("v%0d sum", i), sum, vt[i].s);
      chk($sformatf("v%0d cout", i), cout, vt[i].co);
      chk($sformatf("v%0d busy in done", i), busy, 1);
      @(negedge clk);
      chk($sformatf("v%0d done width", i), done, 0);
      chk($sformatf("v%0d idle busy", i), busy, 0);
    end
    launch(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    got_s = '0;
    got_c = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (done) begin
        ndone++;
        got_s = sum;
        got_c = cout;
      end
      @(negedge clk);
    end
    chk("run ignore done count", ndone, 1);
    chk("run ignore sum", got_s, 8'h30);
    chk("run ignore cout", got_c, 0);
    launch(8'h7F, 8'h7F, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("sum held during run", sum, 8'h30);
    chk("cout held during run", cout, 0);
    wait_done(lat);
    chk("held op sum", sum, 8'hFF);
    @(negedge clk);
    launch(8'h11, 8'h22, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort no done", ndone, 0);
    launch(8'h7F, 8'h01, 1'b0);
    wait_done(lat);
    chk("after abort latency", lat, 9);
    chk("after abort sum", sum, 8'h80);
    chk("after abort cout", cout, 0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = hs[0].a;
    b = hs[0].b;
    cin = hs[0].cin;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      gap = 1;
      while (!done && gap < 40) begin
        @(negedge clk);
        gap++;
      end
      chk($sformatf("held start gap %0d", i), gap, i == 0 ? 9 : 10);
      chk($sformatf("held start sum %0d", i), sum, hs[i].s);
      chk($sformatf("held start cout %0d", i), cout, hs[i].co);
      if (i < 2) begin
        a = hs[i+1].a;
        b = hs[i+1].b;
        cin = hs[i+1].cin;
      end
      @(negedge clk);
    end
    start = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while in RUN or DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  registered carry-out of the addition.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->DONE after exactly WIDTH RUN cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL, on accepting start, load a and b into shift registers, load cin into the carry flip-flop, and clear the bit counter to 0.
REQ-014 SHALL, in each RUN cycle, add the LSBs of both shift registers with the carry flip-flop, shift both registers right by one, shift the sum bit into the MSB of the partial-sum register, update the carry flip-flop, and increment the counter.
REQ-015 SHALL leave RUN when the counter reaches WIDTH-1 on that cycle's edge, so the sequence occupies exactly WIDTH RUN cycles.
REQ-016 SHALL update sum and cout only on the RUN->DONE edge, from the completed partial-sum register and the final carry.
REQ-017 SHALL hold sum and cout stable from that edge until the next RUN->DONE edge, including throughout any following RUN.
REQ-018 SHALL assert done for exactly one cycle, while in DONE; busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-019 SHALL meet this latency: start sampled at edge k causes done=1 in the cycle after edge k+WIDTH, and IDLE again after edge k+WIDTH+1.
REQ-020 SHALL ignore start while in RUN or DONE, with no effect on operands, counter or result.
REQ-021 SHALL accept a start held high across the DONE->IDLE edge at the first IDLE edge, giving back-to-back operations with exactly one IDLE cycle between them.
REQ-022 SHALL ignore changes on a, b and cin when no start is being accepted.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, go to IDLE and clear counter, carry flip-flop, shift registers, sum (0), cout (0), done (0) and busy (0).
REQ-024 SHALL give rst priority over start and abandon any operation in progress, with no done pulse for it.

Structure
REQ-025 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant in shared package serial_pkg.
REQ-026 SHALL instantiate one combinational sub-module full_adder (a, b, cin -> s, cout) for the per-bit addition.
REQ-027 SHALL size the bit counter to $clog2(WIDTH) bits, with no other arithmetic wider than one bit.

Verification
REQ-028 SHALL cover, with WIDTH=8: a=8'h03, b=8'h05, cin=0, start pulse -> done after 9 cycles, sum=8'h08, cout=0.
REQ-029 SHALL cover: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
REQ-030 SHALL cover: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
REQ-031 SHALL cover: start a=8'h10, b=8'h20, then pulse start with a=8'hAA, b=8'h55 during RUN -> sum=8'h30, cout=0, exactly one done pulse.
REQ-032 SHALL cover: rst=1 at RUN cycle 4 -> busy=0, done never pulses, sum=0; a following start with a=8'h7F, b=8'h01 -> sum=8'h80, cout=0.
REQ-033 SHALL cover: start held high continuously -> done pulses every WIDTH+2 cycles, with each result matching the operands present at its accept edge.
